// File: rtl/mcu51_dataram_pkg.sv
// mcu51_dataram_pkg: op encodings, FSM states and address constants for the data RAM sequencer
package mcu51_dataram_pkg;
  typedef enum logic [2:0] {
    OP_RD_DIR = 3'b000,
    OP_WR_DIR = 3'b001,
    OP_RD_BIT = 3'b010,
    OP_WR_BIT = 3'b011,
    OP_RD_RN  = 3'b100,
    OP_WR_RN  = 3'b101,
    OP_RD_IND = 3'b110,
    OP_WR_IND = 3'b111
  } op_t;
  typedef enum logic [1:0] {K_DIR, K_BIT, K_RN, K_IND} kind_t;
  typedef enum logic [2:0] {S_IDLE, S_PTR, S_PWAIT, S_ACC, S_WAIT, S_RESP} state_t;
  localparam logic [7:0] BIT_BASE_DEF = 8'h20;
  localparam logic [7:0] ADDR_LIMIT = 8'h80;
  function automatic kind_t op_kind(logic [2:0] op);
    return kind_t'(op[2:1]);
  endfunction
endpackage

// File: rtl/dataram_access_ctrl_if.sv
// dataram_access_ctrl_if: request/response handshake plus RAM port of the data RAM sequencer
interface dataram_access_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_arg;
  logic [7:0] req_wdata;
  logic       req_wbit;
  logic [1:0] bank;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_bit;
  logic       rsp_err;
  logic       ram_cs;
  logic       ram_rw;
  logic       ram_bb;
  logic [7:0] ram_addr;
  logic [7:0] ram_position;
  logic [7:0] ram_din;
  logic       ram_bin;
  logic [7:0] ram_dout;
  logic       ram_bout;
  modport slave (
    input  req_valid, req_op, req_arg, req_wdata, req_wbit, bank, ram_dout, ram_bout,
    output req_ready, rsp_valid, rsp_data, rsp_bit, rsp_err,
           ram_cs, ram_rw, ram_bb, ram_addr, ram_position, ram_din, ram_bin
  );
  modport master (
    output req_valid, req_op, req_arg, req_wdata, req_wbit, bank, ram_dout, ram_bout,
    input  req_ready, rsp_valid, rsp_data, rsp_bit, rsp_err,
           ram_cs, ram_rw, ram_bb, ram_addr, ram_position, ram_din, ram_bin
  );
endinterface

// File: rtl/mcu51_bitaddr_map.sv
// mcu51_bitaddr_map: bit address to byte address, one-hot position and out-of-range flag
module mcu51_bitaddr_map
  import mcu51_dataram_pkg::*;
#(
  parameter logic [7:0] BIT_BASE = BIT_BASE_DEF
) (
  input  logic [7:0] bit_addr,
  output logic [7:0] byte_addr,
  output logic [7:0] position,
  output logic       oor
);
  assign byte_addr = BIT_BASE + {4'h0, bit_addr[6:3]};
  assign position  = 8'h01 << bit_addr[2:0];
  assign oor       = bit_addr >= ADDR_LIMIT;
endmodule

// File: rtl/dataram_access_ctrl.sv
// dataram_access_ctrl: sequences 8051 direct/bit/Rn/@Ri requests onto the internal data RAM port
module dataram_access_ctrl
  import mcu51_dataram_pkg::*;
#(
  parameter int         RD_LAT   = 1,
  parameter logic [7:0] BIT_BASE = BIT_BASE_DEF
) (
  input logic clk,
  input logic reset,
  dataram_access_ctrl_if.slave bus
);
  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] arg_q, arg_d, wdata_q, wdata_d, target_q, target_d;
  logic       wbit_q, wbit_d;
  logic [1:0] bank_q, bank_d;
  logic       req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic       rsp_err_q, rsp_err_d, rsp_bit_q, rsp_bit_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       ram_cs_q, ram_cs_d, ram_rw_q, ram_rw_d, ram_bb_q, ram_bb_d, ram_bin_q, ram_bin_d;
  logic [7:0] ram_addr_q, ram_addr_d, ram_position_q, ram_position_d, ram_din_q, ram_din_d;
  logic       accept, ptr_sample, rd_sample, ptr_bad, req_bad, err_now;
  logic       act, ptr, wr_acc, bit_op, bit_oor;
  logic [7:0] bit_byte, bit_pos;
  kind_t      kind_d;
  mcu51_bitaddr_map #(.BIT_BASE(BIT_BASE)) u_map (
    .bit_addr (arg_d),
    .byte_addr(bit_byte),
    .position (bit_pos),
    .oor      (bit_oor)
  );
  // request capture and sampling points; later bank changes are ignored
  always_comb begin
    accept     = bus.req_valid && req_ready_q;
    op_d       = accept ? bus.req_op : op_q;
    arg_d      = accept ? bus.req_arg : arg_q;
    wdata_d    = accept ? bus.req_wdata : wdata_q;
    wbit_d     = accept ? bus.req_wbit : wbit_q;
    bank_d     = accept ? bus.bank : bank_q;
    kind_d     = op_kind(op_d);
    bit_op     = kind_d == K_BIT;
    ptr_bad    = bus.ram_dout >= ADDR_LIMIT;
    ptr_sample = (RD_LAT == 0) ? state_q == S_PTR : state_q == S_PWAIT;
    rd_sample  = !op_d[0] && ((RD_LAT == 0) ? state_q == S_ACC : state_q == S_WAIT);
    req_bad    = accept && (kind_d == K_DIR || bit_op) && bit_oor;
    err_now    = req_bad || (ptr_sample && ptr_bad);
    target_d   = accept ? bus.req_arg : ptr_sample ? bus.ram_dout : target_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = !accept ? S_IDLE : kind_d == K_IND ? S_PTR : req_bad ? S_RESP : S_ACC;
      S_PTR:   state_d = (RD_LAT != 0) ? S_PWAIT : ptr_bad ? S_RESP : S_ACC;
      S_PWAIT: state_d = ptr_bad ? S_RESP : S_ACC;
      S_ACC:   state_d = (op_d[0] || RD_LAT == 0) ? S_RESP : S_WAIT;
      S_WAIT:  state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  // outputs are decoded from the next state so every port comes straight from a flop
  always_comb begin
    act            = state_d inside {S_PTR, S_PWAIT, S_ACC, S_WAIT};
    ptr            = state_d inside {S_PTR, S_PWAIT};
    wr_acc         = state_d == S_ACC && op_d[0];
    req_ready_d    = state_d == S_IDLE;
    rsp_valid_d    = state_d == S_RESP;
    rsp_err_d      = err_now;
    rsp_data_d     = (rd_sample && !bit_op) ? bus.ram_dout : 8'h00;
    rsp_bit_d      = rd_sample && bit_op && bus.ram_bout;
    ram_cs_d       = !act;
    ram_rw_d       = !wr_acc;
    ram_bb_d       = !(act && !ptr && bit_op);
    ram_addr_d     = !act ? 8'h00 :
                     ptr ? {3'b000, bank_d, 2'b00, arg_d[0]} :
                     kind_d == K_RN ? {3'b000, bank_d, arg_d[2:0]} :
                     bit_op ? bit_byte : target_d;
    ram_position_d = (act && !ptr && bit_op) ? bit_pos : 8'h00;
    ram_din_d      = (wr_acc && !bit_op) ? wdata_d : 8'h00;
    ram_bin_d      = wr_acc && bit_op && wbit_d;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      op_q           <= 3'b000;
      arg_q          <= 8'h00;
      wdata_q        <= 8'h00;
      wbit_q         <= 1'b0;
      bank_q         <= 2'b00;
      target_q       <= 8'h00;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_bit_q      <= 1'b0;
      rsp_data_q     <= 8'h00;
      ram_cs_q       <= 1'b1;
      ram_rw_q       <= 1'b1;
      ram_bb_q       <= 1'b1;
      ram_addr_q     <= 8'h00;
      ram_position_q <= 8'h00;
      ram_din_q      <= 8'h00;
      ram_bin_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      arg_q          <= arg_d;
      wdata_q        <= wdata_d;
      wbit_q         <= wbit_d;
      bank_q         <= bank_d;
      target_q       <= target_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_bit_q      <= rsp_bit_d;
      rsp_data_q     <= rsp_data_d;
      ram_cs_q       <= ram_cs_d;
      ram_rw_q       <= ram_rw_d;
      ram_bb_q       <= ram_bb_d;
      ram_addr_q     <= ram_addr_d;
      ram_position_q <= ram_position_d;
      ram_din_q      <= ram_din_d;
      ram_bin_q      <= ram_bin_d;
    end
  end
  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_bit      = rsp_bit_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.ram_cs       = ram_cs_q;
  assign bus.ram_rw       = ram_rw_q;
  assign bus.ram_bb       = ram_bb_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_position = ram_position_q;
  assign bus.ram_din      = ram_din_q;
  assign bus.ram_bin      = ram_bin_q;
endmodule

// File: tb/tb_dataram_access_ctrl.sv
// tb_dataram_access_ctrl: table-driven bench with a registered RAM model and reset-abort sequences
module tb_dataram_access_ctrl;
  import mcu51_dataram_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  dataram_access_ctrl_if bus();
  dataram_access_ctrl #(.RD_LAT(1), .BIT_BASE(8'h20)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  logic [7:0] mem [128] = '{default: 8'h00};
  int wr_cnt = 0;
  int cs_cnt = 0;
  int viol = 0;
  logic [7:0] wa = 8'h00;
  logic [7:0] wp = 8'h00;
  logic wbb = 1'b1;
  // RAM model with one cycle of read latency; also tallies chip-select and write cycles
  always @(posedge clk) begin
    if (!bus.ram_cs) begin
      cs_cnt <= cs_cnt + 1;
      if (!bus.ram_rw) begin
        wr_cnt <= wr_cnt + 1;
        wa <= bus.ram_addr;
        wp <= bus.ram_position;
        wbb <= bus.ram_bb;
        mem[bus.ram_addr[6:0]] <= bus.ram_bb ? bus.ram_din :
          (mem[bus.ram_addr[6:0]] & ~bus.ram_position) | (bus.ram_bin ? bus.ram_position : 8'h00);
      end else begin
        bus.ram_dout <= mem[bus.ram_addr[6:0]];
        bus.ram_bout <= |(mem[bus.ram_addr[6:0]] & bus.ram_position);
      end
    end
    if ((bus.ram_cs && !bus.ram_rw) || (bus.rsp_valid && bus.req_ready)) viol <= viol + 1;
  end
  int n_tot = 0;
  int n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".ctl"}, {24'h0, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_bit,
        bus.ram_cs, bus.ram_rw, bus.ram_bb, bus.ram_bin}, 32'b1000_1110);
    chk({tag, ".bus"}, {bus.rsp_data, bus.ram_addr, bus.ram_position, bus.ram_din}, 32'h0);
  endtask
  task automatic run(input op_t op, input logic [7:0] arg, input logic [7:0] wdata,
                     input logic wbit, input logic [1:0] bk, output logic [7:0] d,
                     output logic b, output logic e, output int lat, output int nwr, output int ncs);
    int w0, c0;
    @(negedge clk);
    chk("ready_idle", {30'h0, bus.req_ready, bus.rsp_valid}, 32'h2);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_arg = arg;
    bus.req_wdata = wdata;
    bus.req_wbit = wbit;
    bus.bank = bk;
    w0 = wr_cnt;
    c0 = cs_cnt;
    @(posedge clk);
    lat = 99;
    d = 8'h00;
    b = 1'b0;
    e = 1'b0;
    for (int i = 1; i <= 20 && lat == 99; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.bank = ~bk;
      if (bus.rsp_valid) begin
        lat = i;
        d = bus.rsp_data;
        b = bus.rsp_bit;
        e = bus.rsp_err;
      end
    end
    nwr = wr_cnt - w0;
    ncs = cs_cnt - c0;
  endtask
  typedef struct {
    op_t op; logic [7:0] arg; logic [7:0] wdata; logic wbit; logic [1:0] bank;
    logic [7:0] d; logic b; logic e; int lat; int nwr; int ncs; logic [7:0] wa; logic [7:0] wp;
  } vec_t;
  vec_t v [28];
  initial begin
    string s;
    logic [7:0] d;
    logic b, e;
    int lat, nwr, ncs, w0;
    bit seen;
    bus.req_valid = 1'b0;
    bus.req_op = 3'b000;
    bus.req_arg = 8'h00;
    bus.req_wdata = 8'h00;
    bus.req_wbit = 1'b0;
    bus.bank = 2'b00;
    v[0]  = '{OP_WR_DIR, 8'h45, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2, 1, 1, 8'h45, 8'h00};
    v[1]  = '{OP_RD_DIR, 8'h45, 8'h00, 1'b0, 2'd3, 8'hA5, 1'b0, 1'b0, 3, 0, 2, 8'h00, 8'h00};
    v[2]  = '{OP_WR_RN,  8'h03, 8'h3C, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 2, 1, 1, 8'h13, 8'h00};
    v[3]  = '{OP_RD_DIR, 8'h13, 8'h00, 1'b0, 2'd0, 8'h3C, 1'b0, 1'b0, 3, 0, 2, 8'h00, 8'h00};
    v[4]  = '{OP_WR_DIR, 8'h21, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2, 1, 1, 8'h21, 8'h00};
    v[5]  = '{OP_WR_BIT, 8'h0B, 8'h00, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 2, 1, 1, 8'h21, 8'h08};
    v[6]  = '{OP_RD_DIR, 8'h21, 8'h00, 1'b0, 2'd0, 8'h08, 1'b0, 1'b0, 3, 0, 2, 8'h00, 8'h00};
    v[7]  = '{OP_RD_BIT, 8'h0B, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 3, 0, 2, 8'h00, 8'h00};
    v[8]  = '{OP_RD_BIT, 8'h0C, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3, 0, 2, 8'h00, 8'h00};
    v[9]  = '{OP_WR_DIR, 8'h01, 8'h50, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2, 1, 1, 8'h01, 8'h00};
    v[10] = '{OP_WR_DIR, 8'h50, 8'h77, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2, 1, 1, 8'h50, 8'h00};
    v[11] = '{OP_RD_IND, 8'h01, 8'h00, 1'b0, 2'd0, 8'h77, 1'b0, 1'b0, 5, 0, 4, 8'h00, 8'h00};
    v[12] = '{OP_WR_IND, 8'h01, 8'h99, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4, 1, 3, 8'h50, 8'h00};
    v[13] = '{OP_RD_DIR, 8'h50, 8'h00, 1'b0, 2'd3, 8'h99, 1'b0, 1'b0, 3, 0, 2, 8'h00, 8'h00};
    v[14] = '{OP_RD_DIR, 8'h90, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00, 8'h00};
    v[15] = '{OP_WR_BIT, 8'h88, 8'h00, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00, 8'h00};
    v[16] = '{OP_WR_DIR, 8'h08, 8'hC0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2, 1, 1, 8'h08, 8'h00};
    v[17] = '{OP_WR_IND, 8'h00, 8'h11, 1'b0, 2'd1, 8'h00, 1'b0, 1'b1, 3, 0, 2, 8'h00, 8'h00};
    v[18] = '{OP_WR_DIR, 8'h7F, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2, 1, 1, 8'h7F, 8'h00};
    v[19] = '{OP_WR_DIR, 8'h19, 8'h7F, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2, 1, 1, 8'h19, 8'h00};
    v[20] = '{OP_RD_IND, 8'h01, 8'h00, 1'b0, 2'd3, 8'h5A, 1'b0, 1'b0, 5, 0, 4, 8'h00, 8'h00};
    v[21] = '{OP_RD_RN,  8'h03, 8'h00, 1'b0, 2'd2, 8'h3C, 1'b0, 1'b0, 3, 0, 2, 8'h00, 8'h00};
    v[22] = '{OP_WR_BIT, 8'h7F, 8'h00, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 2, 1, 1, 8'h2F, 8'h80};
    v[23] = '{OP_RD_DIR, 8'h2F, 8'h00, 1'b0, 2'd0, 8'h80, 1'b0, 1'b0, 3, 0, 2, 8'h00, 8'h00};
    v[24] = '{OP_WR_BIT, 8'h0B, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2, 1, 1, 8'h21, 8'h08};
    v[25] = '{OP_RD_DIR, 8'h21, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3, 0, 2, 8'h00, 8'h00};
    v[26] = '{OP_RD_DIR, 8'h80, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00, 8'h00};
    v[27] = '{OP_WR_DIR, 8'h80, 8'hFF, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00, 8'h00};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    reset = 1'b1;
    for (int i = 0; i < 28; i++) begin
      run(v[i].op, v[i].arg, v[i].wdata, v[i].wbit, v[i].bank, d, b, e, lat, nwr, ncs);
      s = $sformatf("v%0d", i);
      chk({s, ".data"}, {24'h0, d}, {24'h0, v[i].d});
      chk({s, ".bit"}, {31'h0, b}, {31'h0, v[i].b});
      chk({s, ".err"}, {31'h0, e}, {31'h0, v[i].e});
      chk({s, ".lat"}, lat, v[i].lat);
      chk({s, ".nwr"}, nwr, v[i].nwr);
      chk({s, ".ncs"}, ncs, v[i].ncs);
      if (v[i].nwr != 0) begin
        chk({s, ".waddr"}, {24'h0, wa}, {24'h0, v[i].wa});
        chk({s, ".wpos"}, {24'h0, wp}, {24'h0, v[i].wp});
        chk({s, ".wbb"}, {31'h0, wbb}, (v[i].op == OP_WR_BIT) ? 32'h0 : 32'h1);
      end
    end
    // reset during WAIT of an indirect read: no response, then normal service
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = OP_RD_IND;
    bus.req_arg = 8'h01;
    bus.bank = 2'd0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_phase", {22'h0, bus.ram_cs, bus.ram_rw, bus.ram_addr}, {22'h0, 1'b0, 1'b1, 8'h50});
    reset = 1'b0;
    @(negedge clk);
    chk_reset("abort_rd");
    reset = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid;
    end
    chk("abort_rd.no_rsp", {31'h0, seen}, 32'h0);
    run(OP_RD_DIR, 8'h50, 8'h00, 1'b0, 2'd0, d, b, e, lat, nwr, ncs);
    chk("after_abort.data", {24'h0, d}, 32'h99);
    chk("after_abort.lat", lat, 3);
    // reset during PTR of an indirect write: RAM must stay untouched
    @(negedge clk);
    w0 = wr_cnt;
    bus.req_valid = 1'b1;
    bus.req_op = OP_WR_IND;
    bus.req_arg = 8'h01;
    bus.req_wdata = 8'hEE;
    bus.bank = 2'd0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("ptr_phase", {22'h0, bus.ram_cs, bus.ram_rw, bus.ram_addr}, {22'h0, 1'b0, 1'b1, 8'h01});
    reset = 1'b0;
    @(negedge clk);
    chk_reset("abort_wr");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_wr.nowr", wr_cnt - w0, 0);
    run(OP_RD_DIR, 8'h50, 8'h00, 1'b0, 2'd0, d, b, e, lat, nwr, ncs);
    chk("abort_wr.mem", {24'h0, d}, 32'h99);
    chk("protocol", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/dataram_access_ctrl.md
Name: dataram_access_ctrl

Overview:
Sequencer that sits directly upstream of the 128-byte internal data RAM (Rn banks, bit area 0x20-0x2F, byte area 0x30-0x7F). It accepts 8051-style access requests (direct byte, bit, Rn, indirect @Ri) over a valid/ready handshake. It resolves register-bank, bit-address and pointer indirection into RAM chip-select, read/write, byte/bit, addr and one-hot position signals. It then returns read data or completion on a one-cycle response pulse.

Parameters:
RD_LAT, 1, RAM read latency in cycles after CS asserted (legal 0 or 1)
BIT_BASE, 8'h20, byte address of bit-addressable area

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_op  in  3  000 RD_DIR, 001 WR_DIR, 010 RD_BIT, 011 WR_BIT, 100 RD_RN, 101 WR_RN, 110 RD_IND, 111 WR_IND
req_arg  in  8  direct addr / bit addr / Rn index [2:0] / Ri index [0]
req_wdata  in  8  write byte
req_wbit  in  1  write bit
bank  in  2  PSW RS1:RS0
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  8  read byte (0 for writes/bit ops)
rsp_bit  out  1  read bit (0 otherwise)
rsp_err  out  1  request rejected, no RAM write performed
ram_cs  out  1  RAM chip select, low active
ram_rw  out  1  high read, low write
ram_bb  out  1  high byte, low bit
ram_addr  out  8  RAM address
ram_position  out  8  one-hot bit position
ram_din  out  8  RAM write byte
ram_bin  out  1  RAM write bit
ram_dout  in  8  RAM read byte
ram_bout  in  1  RAM read bit

Behaviour:
- Reset (reset=0 at clk edge): state IDLE; req_ready=1; rsp_valid/rsp_err/rsp_bit=0; rsp_data=0; ram_cs=1, ram_rw=1, ram_bb=1, ram_addr/position/din=0, ram_bin=0. Reset mid-operation aborts with no response; a write not yet in ACC never reaches RAM.
- All outputs registered. Request captured (op, arg, wdata, wbit, bank) on req_valid & req_ready; later bank changes ignored.
- States: IDLE, PTR, PWAIT, ACC, WAIT, RESP.
- IDLE -> PTR for RD_IND/WR_IND; -> RESP with rsp_err for direct/bit arg >= 8'h80 (upper RAM/SFR not served here); else -> ACC.
- PTR: cs=0, rw=1, bb=1, addr={3'b000,bank,2'b00,arg[0]}; RD_LAT=1 -> PWAIT (cs held) then sample; RD_LAT=0 sample at end of PTR. Pointer >= 8'h80 -> RESP with err; else pointer becomes target, -> ACC.
- ACC address rules: DIR/IND addr=target, bb=1; RN addr={3'b000,bank,arg[2:0]}, bb=1; BIT addr=BIT_BASE+arg[6:3], bb=0, position=1<<arg[2:0]. Byte ops drive position=0.
- ACC writes: cs=0 for exactly one cycle, rw=0, din=wdata (byte) / bin=wbit (bit); -> RESP.
- ACC reads: cs=0, rw=1; RD_LAT=0 sample ram_dout/ram_bout at end of ACC; RD_LAT=1 -> WAIT (cs held low), sample at end of WAIT; -> RESP.
- RESP: rsp_valid=1 one cycle, cs=1, rw=1, bb=1; -> IDLE. req_ready=0 in RESP; back-to-back request accepted the cycle after RESP.
- Latency (accept cycle T, RD_LAT=1): write rsp at T+2; byte/bit/Rn read T+3; indirect read T+5; indirect write T+4; error T+1 (indirect ptr error T+3).
- ram_rw never low while ram_cs high; ram_cs high in every state except PTR/PWAIT/ACC/WAIT.

Decomposition:
- Package mcu51_dataram_pkg: op encodings, state enum, BIT_BASE default, ADDR_LIMIT=8'h80.
- Sub-module mcu51_bitaddr_map: combinational bit address -> {byte addr, one-hot position, out-of-range flag}.

Test Plan:
- WR_DIR arg=8'h45 wdata=8'hA5 then RD_DIR 8'h45 -> one write cycle cs=0 rw=0 addr=8'h45; read rsp_data=8'hA5, rsp_err=0, latency 2/3.
- bank=2'b10, WR_RN arg=3 wdata=8'h3C, then RD_DIR 8'h13 -> ram_addr=8'h13 on write; read returns 8'h3C.
- WR_BIT arg=8'h0B wbit=1 -> addr=8'h21, position=8'h08, bb=0; RD_DIR 8'h21 after clearing returns 8'h08; RD_BIT 8'h0B rsp_bit=1.
- bank=0, R1=8'h50, mem[50]=8'h77; RD_IND arg=1 -> PTR addr=8'h01 then ACC addr=8'h50, rsp_data=8'h77 at T+5.
- RD_DIR 8'h90, WR_BIT 8'h88, WR_IND with Ri=8'hC0 -> rsp_err=1, no cs=0 write cycle, rsp_data=0.
- Assert reset low during WAIT of RD_IND -> next cycle all reset values, no rsp_valid; next request served normally.
